// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the external SRAM.
//   Fetch port : if_req, if_addr -> if_ready, if_rdata
//   Data port  : mem_rd_req, mem_wr_req, mem_addr, mem_wdata -> mem_ready, mem_rdata
//   Status     : grant_data (current transaction belongs to the data port)
//   SRAM side  : sram_addr, sram_dq_out, sram_dq_oe, sram_we_n -> / <- sram_dq_in
// modport slave is the arbiter's view; modport master is the pipeline/SRAM view.
interface mem_port_arbiter_if #(
  parameter int unsigned SRAM_AW = 17
);
  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_ready;
  logic [31:0]        if_rdata;
  logic               mem_rd_req;
  logic               mem_wr_req;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_ready;
  logic [31:0]        mem_rdata;
  logic               grant_data;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  modport slave (
    input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, sram_dq_in,
    output if_ready, if_rdata, mem_ready, mem_rdata, grant_data,
    output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, sram_dq_in,
    input  if_ready, if_rdata, mem_ready, mem_rdata, grant_data,
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit SRAM between the fetch port and the data port.
// Each 32-bit access is split into a LO and a HI half-word phase of WAIT_CYC+1 cycles,
// followed by a one-cycle DONE state that pulses the served port's ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave: fetch/data request ports and SRAM pins
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYC  = 2,
  parameter int unsigned DATA_BASE = 1024,
  parameter int unsigned SRAM_AW   = 17
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state;
  logic [2:0]         cnt;
  logic               last_data;   // 1: data port was served most recently
  logic               cur_data;
  logic               cur_write;
  logic [15:0]        word;
  logic [31:0]        wdata;
  logic [15:0]        lo_data;

  logic               if_ready_q;
  logic [31:0]        if_rdata_q;
  logic               mem_ready_q;
  logic [31:0]        mem_rdata_q;
  logic               grant_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [15:0]        sram_dq_out_q;
  logic               sram_dq_oe_q;
  logic               sram_we_n_q;

  logic               data_req;
  logic               any_req;
  logic               pick_data;
  logic               pick_write;
  logic [31:0]        data_off;
  logic [15:0]        acc_word;
  logic               phase_end;

  assign data_req   = bus.mem_rd_req | bus.mem_wr_req;
  assign any_req    = bus.if_req | data_req;
  // Data wins when fetch is idle, or on a tie when fetch was served last.
  assign pick_data  = data_req & (~bus.if_req | ~last_data);
  // Read+write together is a store.
  assign pick_write = pick_data & bus.mem_wr_req;
  assign data_off   = bus.mem_addr - 32'(DATA_BASE);
  assign acc_word   = pick_data ? data_off[17:2] : bus.if_addr[17:2];
  assign phase_end  = (cnt == 3'(WAIT_CYC));

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_off[31:18], data_off[1:0],
                              bus.if_addr[31:18], bus.if_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= StIdle;
      cnt           <= 3'd0;
      last_data     <= 1'b0;
      cur_data      <= 1'b0;
      cur_write     <= 1'b0;
      word          <= 16'd0;
      wdata         <= 32'd0;
      lo_data       <= 16'd0;
      if_ready_q    <= 1'b0;
      if_rdata_q    <= 32'd0;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= 32'd0;
      grant_data_q  <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= 16'd0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (any_req) begin
            cur_data     <= pick_data;
            cur_write    <= pick_write;
            word         <= acc_word;
            wdata        <= bus.mem_wdata;
            cnt          <= 3'd0;
            grant_data_q <= pick_data;
            sram_addr_q  <= SRAM_AW'({acc_word, 1'b0});
            sram_we_n_q  <= ~pick_write;
            sram_dq_oe_q <= pick_write;
            if (pick_write) begin
              sram_dq_out_q <= bus.mem_wdata[15:0];
            end
            state        <= StLo;
          end
        end
        StLo: begin
          if (phase_end) begin
            lo_data     <= bus.sram_dq_in;
            cnt         <= 3'd0;
            sram_addr_q <= SRAM_AW'({word, 1'b1});
            if (cur_write) begin
              sram_dq_out_q <= wdata[31:16];
            end
            state       <= StHi;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        StHi: begin
          if (phase_end) begin
            // Ready and read data become visible together in DONE.
            if (cur_data) begin
              mem_ready_q <= 1'b1;
              if (!cur_write) begin
                mem_rdata_q <= {bus.sram_dq_in, lo_data};
              end
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= {bus.sram_dq_in, lo_data};
            end
            sram_we_n_q  <= 1'b1;
            sram_dq_oe_q <= 1'b0;
            state        <= StDone;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        StDone: begin
          if_ready_q   <= 1'b0;
          mem_ready_q  <= 1'b0;
          grant_data_q <= 1'b0;
          last_data    <= cur_data;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.if_ready    = if_ready_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.grant_data  = grant_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;
  assign bus.sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model checks instance u0 every cycle,
// directed tests pin latencies, SRAM contents and data words with literal values.
module tb_mem_port_arbiter;

  localparam int W0 = 2;
  localparam int P  = W0 + 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_port_arbiter_if #(.SRAM_AW(17)) b0 ();
  mem_port_arbiter_if #(.SRAM_AW(17)) b1 ();

  mem_port_arbiter #(.WAIT_CYC(W0), .DATA_BASE(1024), .SRAM_AW(17)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mem_port_arbiter #(.WAIT_CYC(0), .DATA_BASE(1024), .SRAM_AW(17)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Physical SRAM (written only by u0) and the model's shadow copy.
  logic [15:0] sram   [0:1023];
  logic [15:0] shadow [0:1023];

  assign b0.sram_dq_in = sram[b0.sram_addr[9:0]];
  assign b1.sram_dq_in = sram[b1.sram_addr[9:0]];

  always @(posedge clk) begin
    if (!b0.sram_we_n && b0.sram_dq_oe) sram[b0.sram_addr[9:0]] = b0.sram_dq_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model of u0 ----------------
  bit          m_busy = 0;
  int          m_t = 0;
  bit          m_data, m_write, m_last_data = 0;
  int          m_word;
  logic [31:0] m_wdata, m_rd_exp;
  logic [31:0] exp_if_rdata = 0, exp_mem_rdata = 0;
  logic        dreq;
  logic [31:0] maddr;
  int          half, idx;

  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 0;
      m_last_data = 0;
      exp_if_rdata = 0;
      exp_mem_rdata = 0;
      chk("rst_if_ready", b0.if_ready, 0);
      chk("rst_mem_ready", b0.mem_ready, 0);
      chk("rst_if_rdata", b0.if_rdata, 0);
      chk("rst_mem_rdata", b0.mem_rdata, 0);
      chk("rst_grant", b0.grant_data, 0);
      chk("rst_sram_addr", b0.sram_addr, 0);
      chk("rst_dq_out", b0.sram_dq_out, 0);
      chk("rst_dq_oe", b0.sram_dq_oe, 0);
      chk("rst_we_n", b0.sram_we_n, 1);
    end else if (m_busy) begin
      m_t++;
      if (m_t <= 2 * P) begin
        half = (m_t > P) ? 1 : 0;
        chk("m_sram_addr", b0.sram_addr, 32'(m_word * 2 + half));
        chk("m_we_n", b0.sram_we_n, m_write ? 0 : 1);
        chk("m_dq_oe", b0.sram_dq_oe, m_write ? 1 : 0);
        if (m_write) chk("m_dq_out", b0.sram_dq_out, half ? m_wdata[31:16] : m_wdata[15:0]);
        chk("m_if_ready", b0.if_ready, 0);
        chk("m_mem_ready", b0.mem_ready, 0);
        chk("m_grant", b0.grant_data, m_data);
      end else begin
        if (!m_write) begin
          if (m_data) exp_mem_rdata = m_rd_exp;
          else exp_if_rdata = m_rd_exp;
        end
        chk("m_done_if_ready", b0.if_ready, m_data ? 0 : 1);
        chk("m_done_mem_ready", b0.mem_ready, m_data ? 1 : 0);
        chk("m_done_grant", b0.grant_data, m_data);
        chk("m_done_we_n", b0.sram_we_n, 1);
        chk("m_done_dq_oe", b0.sram_dq_oe, 0);
        m_last_data = m_data;
        m_busy = 0;
      end
      chk("m_if_rdata", b0.if_rdata, exp_if_rdata);
      chk("m_mem_rdata", b0.mem_rdata, exp_mem_rdata);
    end else begin
      chk("m_idle_if_ready", b0.if_ready, 0);
      chk("m_idle_mem_ready", b0.mem_ready, 0);
      chk("m_idle_grant", b0.grant_data, 0);
      chk("m_idle_we_n", b0.sram_we_n, 1);
      chk("m_idle_dq_oe", b0.sram_dq_oe, 0);
      chk("m_if_rdata", b0.if_rdata, exp_if_rdata);
      chk("m_mem_rdata", b0.mem_rdata, exp_mem_rdata);
      // Requests present in this idle cycle are accepted at its end.
      dreq = b0.mem_rd_req | b0.mem_wr_req;
      if (b0.if_req || dreq) begin
        if (b0.if_req && dreq) m_data = !m_last_data;
        else m_data = dreq;
        m_write = m_data && b0.mem_wr_req;
        maddr = m_data ? (b0.mem_addr - 32'd1024) : b0.if_addr;
        m_word = int'((maddr >> 2) & 32'h0000_FFFF);
        m_wdata = b0.mem_wdata;
        idx = (m_word * 2) % 1024;
        if (m_write) begin
          shadow[idx]     = m_wdata[15:0];
          shadow[idx + 1] = m_wdata[31:16];
        end else begin
          m_rd_exp = {shadow[idx + 1], shadow[idx]};
        end
        m_busy = 1;
        m_t = 0;
      end
    end
  end

  // ---------------- directed tests ----------------
  logic [16:0] addr_log [0:63];
  logic [15:0] dq_log   [0:63];
  logic        we_log   [0:63];

  // Counts cycles from the accepting idle cycle (n=0) to the ready pulse.
  task automatic run_wait(input bit on_data, input int limit, output int lat);
    lat = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      addr_log[n] = b0.sram_addr;
      dq_log[n]   = b0.sram_dq_out;
      we_log[n]   = b0.sram_we_n;
      if (on_data ? b0.mem_ready : b0.if_ready) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) chk("ready_timeout", 0, 1);
  endtask

  int lat;
  int t_prev, t_now;
  bit who;
  bit got;
  bit exp_who [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b0;
    b0.if_req = 0; b0.if_addr = 0; b0.mem_rd_req = 0; b0.mem_wr_req = 0;
    b0.mem_addr = 0; b0.mem_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.mem_rd_req = 0; b1.mem_wr_req = 0;
    b1.mem_addr = 0; b1.mem_wdata = 0;
    for (int i = 0; i < 1024; i++) sram[i] = 16'(i * 7 + 3);
    sram[4] = 16'h5678;
    sram[5] = 16'h1234;
    for (int i = 0; i < 1024; i++) shadow[i] = sram[i];

    repeat (3) @(posedge clk);
    #1 chk("lit_rst_we_n", b0.sram_we_n, 1);
    rst = 1'b1;

    // Fetch of word at byte 8 -> half-words 4/5.
    @(posedge clk); #1;
    b0.if_req = 1; b0.if_addr = 32'h8;
    run_wait(0, 30, lat);
    chk("fetch_latency", lat, 7);
    for (int n = 1; n <= 3; n++) chk("fetch_addr_lo", addr_log[n], 4);
    for (int n = 4; n <= 6; n++) chk("fetch_addr_hi", addr_log[n], 5);
    chk("fetch_rdata", b0.if_rdata, 32'h1234_5678);
    @(posedge clk); #1 b0.if_req = 0;

    // Store to DATA_BASE -> half-words 0/1.
    @(posedge clk); #1;
    b0.mem_wr_req = 1; b0.mem_addr = 32'd1024; b0.mem_wdata = 32'hDEAD_BEEF;
    run_wait(1, 30, lat);
    chk("store_latency", lat, 7);
    chk("store_we_lo", we_log[2], 0);
    chk("store_dq_lo", dq_log[2], 16'hBEEF);
    chk("store_addr_lo", addr_log[2], 0);
    chk("store_we_hi", we_log[5], 0);
    chk("store_dq_hi", dq_log[5], 16'hDEAD);
    chk("store_addr_hi", addr_log[5], 1);
    chk("store_mem_rdata_kept", b0.mem_rdata, 0);
    @(posedge clk); #1 b0.mem_wr_req = 0;
    chk("store_sram0", sram[0], 16'hBEEF);
    chk("store_sram1", sram[1], 16'hDEAD);

    // Load it back.
    @(posedge clk); #1;
    b0.mem_rd_req = 1; b0.mem_addr = 32'd1024;
    run_wait(1, 30, lat);
    chk("load_latency", lat, 7);
    chk("load_rdata", b0.mem_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 b0.mem_rd_req = 0;

    // Both ports requesting continuously from reset: data, fetch, data, fetch.
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    b0.if_req = 1; b0.if_addr = 32'h8;
    b0.mem_rd_req = 1; b0.mem_addr = 32'd1040;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (b0.if_ready || b0.mem_ready) begin
          got = 1;
          who = b0.mem_ready;
          t_now = cyc;
          chk("tie_order", who, exp_who[k]);
          chk("tie_grant", b0.grant_data, exp_who[k]);
          if (k > 0) chk("tie_spacing", t_now - t_prev, 8);
          t_prev = t_now;
        end
      end
      if (!got) chk("tie_timeout", 0, 1);
    end
    @(posedge clk); #1 b0.if_req = 0; b0.mem_rd_req = 0;
    chk("tie_if_rdata", b0.if_rdata, 32'h1234_5678);
    chk("tie_mem_rdata", b0.mem_rdata, 32'h0042_003B);

    // Reset during the HI phase of a store.
    @(posedge clk); #1;
    b0.mem_wr_req = 1; b0.mem_addr = 32'd1036; b0.mem_wdata = 32'hCAFE_F00D;
    for (int n = 0; n <= 5; n++) @(negedge clk);
    #2 rst = 0; b0.mem_wr_req = 0;
    #1 chk("abort_we_n", b0.sram_we_n, 1);
    chk("abort_mem_ready", b0.mem_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    @(posedge clk); #1;
    b0.mem_wr_req = 1;
    run_wait(1, 30, lat);
    chk("restore_latency", lat, 7);
    @(posedge clk); #1 b0.mem_wr_req = 0;
    chk("restore_sram6", sram[6], 16'hF00D);
    chk("restore_sram7", sram[7], 16'hCAFE);

    // Read and write together is a store: half-words 2/3.
    sram[2] = 16'h1111; sram[3] = 16'h2222;
    shadow[2] = 16'h1111; shadow[3] = 16'h2222;
    @(posedge clk); #1;
    b0.mem_rd_req = 1; b0.mem_wr_req = 1; b0.mem_addr = 32'd1028; b0.mem_wdata = 32'h0000_FFFF;
    run_wait(1, 30, lat);
    chk("rdwr_latency", lat, 7);
    chk("rdwr_mem_rdata_kept", b0.mem_rdata, 0);
    @(posedge clk); #1 b0.mem_rd_req = 0; b0.mem_wr_req = 0;
    chk("rdwr_sram2", sram[2], 16'hFFFF);
    chk("rdwr_sram3", sram[3], 16'h0000);
    @(posedge clk); #1;
    b0.mem_rd_req = 1; b0.mem_addr = 32'd1028;
    run_wait(1, 30, lat);
    chk("rdwr_readback", b0.mem_rdata, 32'h0000_FFFF);
    @(posedge clk); #1 b0.mem_rd_req = 0;

    // Zero wait states on the second instance.
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h8;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      addr_log[n] = b1.sram_addr;
      if (b1.if_ready) begin
        lat = n;
        break;
      end
    end
    chk("w0_latency", lat, 3);
    chk("w0_addr_lo", addr_log[1], 4);
    chk("w0_addr_hi", addr_log[2], 5);
    chk("w0_rdata", b1.if_rdata, 32'h1234_5678);
    @(posedge clk); #1 b1.if_req = 0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
